csram_req_master: RTL and testbench

CSRAM_REQ_MASTER -- requirements
Module: csram_req_master

---
 rtl/csram_req_master_pkg.sv | 36 +++
 rtl/csram_wstrb_merge.sv | 19 +
 rtl/csram_req_master.sv | 202 ++++++++++++++++++++
 tb/tb_csram_req_master.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csram_req_master_pkg.sv
// Shared definitions for the CSRAM request master: FSM state encoding,
// default timeout limit, word-address LSB and an address alignment helper.
package csram_req_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_ISSUE = 3'd1,
      ST_RD_WAIT  = 3'd2,
      ST_MERGE    = 3'd3,
      ST_WR_ISSUE = 3'd4,
      ST_WR_WAIT  = 3'd5,
      ST_RESP     = 3'd6
   } state_e;

   // Default number of wait cycles before an unanswered access is aborted.
   localparam int TIMEOUT_CYC_DEF = 16;

   // Lowest byte-address bit that selects a 32-bit word.
   localparam int ADDR_LSB_DEF = 2;

   localparam logic [3:0] STRB_FULL = 4'hF;
   localparam logic [3:0] STRB_NONE = 4'h0;

   // Clear the byte-offset bits below lsb so the CSRAM sees a word address.
   function automatic logic [31:0] word_align(input logic [31:0] addr, input int lsb);
      logic [31:0] res;
      res = addr;
      for (int b = 0; b < 32; b++) begin
         if (b < lsb) begin
            res[b] = 1'b0;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/csram_wstrb_merge.sv
// Byte-lane merge: each strobed byte comes from the new word, all other
// bytes are kept from the old word read back from the CSRAM.
module csram_wstrb_merge (
   input  logic [31:0] i_old_32b,
   input  logic [31:0] i_new_32b,
   input  logic [3:0]  i_strb_4b,
   output logic [31:0] o_merged_32b
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte
         // One multiplexer per byte lane, selected by its strobe bit.
         assign o_merged_32b[gi*8 +: 8] = i_strb_4b[gi] ? i_new_32b[gi*8 +: 8]
                                                         : i_old_32b[gi*8 +: 8];
      end
   endgenerate

endmodule

// File: rtl/csram_req_master.sv
// CSRAM request master: accepts one CPU read/write at a time and turns it
// into CSRAM read, write or read-modify-write pulses, then returns a
// one-cycle response.
// Optional feature macro: CSRAM_TIMEOUT_EN -- when defined, a wait-cycle
// counter aborts an unanswered access after TIMEOUT_CYC cycles and reports
// it through o_err; when undefined, the wait states wait forever.
module csram_req_master
   import csram_req_master_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int ADDR_LSB    = ADDR_LSB_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [3:0]  i_wstrb_4b,
   input  logic [31:0] i_addr_32b,
   input  logic [31:0] i_wdata_32b,
   output logic        o_ready,
   output logic        o_resp_valid,
   output logic [31:0] o_rdata_32b,
   output logic        o_err,
   output logic [31:0] o_csram_addr_32b,
   output logic        o_csram_wren,
   output logic        o_csram_rden,
   output logic [31:0] o_csram_din_32b,
   input  logic [31:0] i_csram_dout_32b,
   input  logic        i_csram_dout_valid
);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   // Holds the accepted write data until MERGE, then the merged word.
   logic [31:0] din_q, din_d;
   logic [3:0]  strb_q, strb_d;
   logic        rmw_q, rmw_d;
   logic [31:0] rd_word_q, rd_word_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] merged_word;

`ifdef CSRAM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   csram_wstrb_merge u_merge (
      .i_old_32b    (rd_word_q),
      .i_new_32b    (din_q),
      .i_strb_4b    (strb_q),
      .o_merged_32b (merged_word)
   );

   // Next-state and datapath-register updates for the access sequencer.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      din_d     = din_q;
      strb_d    = strb_q;
      rmw_d     = rmw_q;
      rd_word_d = rd_word_q;
      rdata_d   = rdata_q;
`ifdef CSRAM_TIMEOUT_EN
      cnt_d     = cnt_q;
      err_d     = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // Completion pulses seen here belong to an abandoned access.
            if (i_req) begin
               addr_d = word_align(i_addr_32b, ADDR_LSB);
               din_d  = i_we ? i_wdata_32b : 32'h0;
               strb_d = i_wstrb_4b;
               rmw_d  = i_we && (i_wstrb_4b != STRB_FULL) && (i_wstrb_4b != STRB_NONE);
               if (!i_we) begin
                  state_d = ST_RD_ISSUE;
               end else if (i_wstrb_4b == STRB_FULL) begin
                  state_d = ST_WR_ISSUE;
               end else if (i_wstrb_4b == STRB_NONE) begin
                  // Nothing to write: answer without touching the CSRAM.
                  state_d = ST_RESP;
                  rdata_d = 32'h0;
`ifdef CSRAM_TIMEOUT_EN
                  err_d   = 1'b0;
`endif
               end else begin
                  state_d = ST_RD_ISSUE;
               end
            end
         end
         ST_RD_ISSUE: begin
            state_d = ST_RD_WAIT;
`ifdef CSRAM_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         ST_RD_WAIT: begin
            if (i_csram_dout_valid) begin
               rd_word_d = i_csram_dout_32b;
               if (rmw_q) begin
                  state_d = ST_MERGE;
               end else begin
                  state_d = ST_RESP;
                  rdata_d = i_csram_dout_32b;
`ifdef CSRAM_TIMEOUT_EN
                  err_d   = 1'b0;
`endif
               end
            end
`ifdef CSRAM_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               // Abort; an RMW that times out on its read never writes.
               state_d = ST_RESP;
               rdata_d = 32'h0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         ST_MERGE: begin
            din_d   = merged_word;
            state_d = ST_WR_ISSUE;
         end
         ST_WR_ISSUE: begin
            state_d = ST_WR_WAIT;
`ifdef CSRAM_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         ST_WR_WAIT: begin
            if (i_csram_dout_valid) begin
               state_d = ST_RESP;
               rdata_d = 32'h0;
`ifdef CSRAM_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
`ifdef CSRAM_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               state_d = ST_RESP;
               rdata_d = 32'h0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any access in flight.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= 32'h0;
         din_q     <= 32'h0;
         strb_q    <= 4'h0;
         rmw_q     <= 1'b0;
         rd_word_q <= 32'h0;
         rdata_q   <= 32'h0;
`ifdef CSRAM_TIMEOUT_EN
         cnt_q     <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
         strb_q    <= strb_d;
         rmw_q     <= rmw_d;
         rd_word_q <= rd_word_d;
         rdata_q   <= rdata_d;
`ifdef CSRAM_TIMEOUT_EN
         cnt_q     <= cnt_d;
         err_q     <= err_d;
`endif
      end
   end

   assign o_ready          = (state_q == ST_IDLE);
   assign o_resp_valid     = (state_q == ST_RESP);
   assign o_csram_rden     = (state_q == ST_RD_ISSUE);
   assign o_csram_wren     = (state_q == ST_WR_ISSUE);
   assign o_csram_addr_32b = addr_q;
   assign o_csram_din_32b  = din_q;
   assign o_rdata_32b      = rdata_q;
`ifdef CSRAM_TIMEOUT_EN
   assign o_err            = err_q;
`else
   assign o_err            = 1'b0;
`endif

endmodule

// File: tb/tb_csram_req_master.sv
// Self-checking bench for csram_req_master: directed vector table, reset
// sequences, optional timeout sequences (CSRAM_TIMEOUT_EN) and randomized
// traffic checked against a word-array reference memory.
module tb_csram_req_master;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, i_we;
   logic [3:0]  i_wstrb_4b;
   logic [31:0] i_addr_32b, i_wdata_32b;
   logic        o_ready, o_resp_valid, o_err;
   logic [31:0] o_rdata_32b, o_csram_addr_32b, o_csram_din_32b;
   logic        o_csram_wren, o_csram_rden;
   logic [31:0] i_csram_dout_32b;
   logic        i_csram_dout_valid;

   always #5 clk = ~clk;

   csram_req_master dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_req              (i_req),
      .i_we               (i_we),
      .i_wstrb_4b         (i_wstrb_4b),
      .i_addr_32b         (i_addr_32b),
      .i_wdata_32b        (i_wdata_32b),
      .o_ready            (o_ready),
      .o_resp_valid       (o_resp_valid),
      .o_rdata_32b        (o_rdata_32b),
      .o_err              (o_err),
      .o_csram_addr_32b   (o_csram_addr_32b),
      .o_csram_wren       (o_csram_wren),
      .o_csram_rden       (o_csram_rden),
      .o_csram_din_32b    (o_csram_din_32b),
      .i_csram_dout_32b   (i_csram_dout_32b),
      .i_csram_dout_valid (i_csram_dout_valid)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
   endtask

   // CSRAM device model and pulse monitor, sampling 1 ns after each rising edge.
   logic [31:0] dev_mem [0:255];
   logic [31:0] ref_mem [0:255];
   int          cyc = 0;
   int          lat_cfg = 3;
   bit          mute = 1'b0;
   int          cnt = 0;
   bit          pend_wr = 1'b0;
   logic [31:0] pend_addr = 32'h0, pend_din = 32'h0;
   int          n_rd = 0, n_wr = 0, rd_cyc = 0, wr_cyc = 0, last_valid_cyc = -1;
   logic [31:0] rd_addr = 32'h0, wr_addr = 32'h0, wr_din = 32'h0;

   initial begin : csram_model
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         i_csram_dout_valid = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               i_csram_dout_valid = 1'b1;
               last_valid_cyc = cyc;
               if (pend_wr) dev_mem[pend_addr[9:2]] = pend_din;
               else         i_csram_dout_32b = dev_mem[pend_addr[9:2]];
            end
         end
         if (o_csram_rden) begin
            n_rd++; rd_cyc = cyc; rd_addr = o_csram_addr_32b;
            if (!mute) begin cnt = lat_cfg; pend_wr = 1'b0; pend_addr = o_csram_addr_32b; end
         end
         if (o_csram_wren) begin
            n_wr++; wr_cyc = cyc; wr_addr = o_csram_addr_32b; wr_din = o_csram_din_32b;
            if (!mute) begin
               cnt = lat_cfg; pend_wr = 1'b1;
               pend_addr = o_csram_addr_32b; pend_din = o_csram_din_32b;
            end
         end
      end
   end

   // Reference byte merge computed with masks, byte by byte.
   function automatic logic [31:0] merge_ref(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] strb);
      logic [31:0] res, m;
      res = old_w;
      for (int b = 0; b < 4; b++) begin
         m = 32'hFF << (8 * b);
         if (strb[b]) res = (res & ~m) | (new_w & m);
      end
      return res;
   endfunction

   // One CPU transaction; stray bit0 = stray valid with the request,
   // bit1 = stray valid during the response cycle.
   task automatic run_txn(input string name, input bit we, input logic [3:0] strb,
                          input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                          input logic [31:0] exp_rdata, input logic [31:0] exp_din,
                          input int exp_rd, input int exp_wr, input bit exp_err, input int stray);
      int a_cyc, r_cyc, exp_resp, guard;
      lat_cfg = lat;
      @(negedge clk);
      guard = 0;
      while (!o_ready && guard < 100) begin @(negedge clk); guard++; end
      chk({name, "/ready"}, {31'b0, o_ready}, 32'h1);
      n_rd = 0; n_wr = 0; last_valid_cyc = -1;
      i_req = 1'b1; i_we = we; i_wstrb_4b = strb; i_addr_32b = addr; i_wdata_32b = wdata;
      a_cyc = cyc;
      if ((stray & 1) != 0) begin i_csram_dout_valid = 1'b1; i_csram_dout_32b = 32'hBAD0_BAD0; end
      @(negedge clk);
      i_req = 1'b0; i_we = 1'($urandom); i_wstrb_4b = 4'($urandom);
      i_addr_32b = $urandom; i_wdata_32b = $urandom;
      guard = 0;
      while (!o_resp_valid && guard < 200) begin @(negedge clk); guard++; end
      r_cyc = cyc;
      chk({name, "/resp_seen"}, {31'b0, o_resp_valid}, 32'h1);
      if ((stray & 2) != 0) begin i_csram_dout_valid = 1'b1; i_csram_dout_32b = 32'hBAD1_BAD1; end
      chk({name, "/rden_cnt"}, n_rd, exp_rd);
      chk({name, "/wren_cnt"}, n_wr, exp_wr);
      if (exp_rd != 0) begin
         chk({name, "/rd_addr"}, rd_addr, addr & ~32'h3);
         chk({name, "/rd_cyc"}, rd_cyc, a_cyc + 1);
      end
      if (exp_wr != 0) begin
         chk({name, "/wr_addr"}, wr_addr, addr & ~32'h3);
         chk({name, "/wr_din"}, wr_din, exp_din);
         if (exp_rd == 0) chk({name, "/wr_cyc"}, wr_cyc, a_cyc + 1);
      end
      if (exp_err)                          exp_resp = a_cyc + 2 + TO;
      else if (exp_rd == 0 && exp_wr == 0)  exp_resp = a_cyc + 1;
      else                                  exp_resp = last_valid_cyc + 1;
      chk({name, "/resp_cyc"}, r_cyc, exp_resp);
      chk({name, "/rdata"}, o_rdata_32b, exp_rdata);
      chk({name, "/err"}, {31'b0, o_err}, {31'b0, exp_err});
      $display("txn %s we=%0d strb=%h addr=%h rdata=%h err=%0d rd=%0d wr=%0d acc@%0d resp@%0d",
               name, we, strb, addr, o_rdata_32b, o_err, n_rd, n_wr, a_cyc, r_cyc);
      @(negedge clk);
      chk({name, "/resp_pulse_end"}, {31'b0, o_resp_valid}, 32'h0);
      chk({name, "/rdata_hold"}, o_rdata_32b, exp_rdata);
   endtask

   typedef struct {
      string       name;
      bit          we;
      logic [3:0]  strb;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] exp_rdata;
      logic [31:0] exp_din;
      int          exp_rd;
      int          exp_wr;
      int          stray;
   } vec_t;

   vec_t vecs [10];

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int k, w, seen;
      logic [3:0]  strb;
      logic [31:0] addr, wdata, e_rd, e_din;
      int          e_nrd, e_nwr;
      bit          we;

      rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_wstrb_4b = 4'h0;
      i_addr_32b = 32'h0; i_wdata_32b = 32'h0;
      i_csram_dout_32b = 32'h0; i_csram_dout_valid = 1'b0;
      for (int i = 0; i < 256; i++) begin
         dev_mem[i] = $urandom;
         ref_mem[i] = dev_mem[i];
      end
      dev_mem[4] = 32'hDEADBEEF;
      dev_mem[8] = 32'hAABBCCDD;

      vecs[0] = '{"rd_0x10",      1'b0, 4'h0, 32'h10, 32'h0,        3, 32'hDEADBEEF, 32'h0,        1, 0, 0};
      vecs[1] = '{"wr_full_0x13", 1'b1, 4'hF, 32'h13, 32'h12345678, 2, 32'h0,        32'h12345678, 0, 1, 0};
      vecs[2] = '{"rd_back_0x10", 1'b0, 4'h0, 32'h10, 32'h0,        1, 32'h12345678, 32'h0,        1, 0, 0};
      vecs[3] = '{"rmw_0101",     1'b1, 4'h5, 32'h20, 32'h11223344, 3, 32'h0,        32'hAA22CC44, 1, 1, 0};
      vecs[4] = '{"rd_0x22",      1'b0, 4'h0, 32'h22, 32'h0,        4, 32'hAA22CC44, 32'h0,        1, 0, 0};
      vecs[5] = '{"wr_strb0",     1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 3, 32'h0,        32'h0,        0, 0, 0};
      vecs[6] = '{"rd_stray",     1'b0, 4'h0, 32'h21, 32'h0,        2, 32'hAA22CC44, 32'h0,        1, 0, 3};
      vecs[7] = '{"rmw_1000",     1'b1, 4'h8, 32'h10, 32'h99000000, 1, 32'h0,        32'h99345678, 1, 1, 1};
      vecs[8] = '{"rmw_0110",     1'b1, 4'h6, 32'h23, 32'h55667788, 5, 32'h0,        32'hAA667744, 1, 1, 2};
      vecs[9] = '{"rd_0x20",      1'b0, 4'h0, 32'h20, 32'h0,        1, 32'hAA667744, 32'h0,        1, 0, 0};

      // Reset state, then release.
      repeat (3) @(negedge clk);
      chk("rst/resp_valid", {31'b0, o_resp_valid}, 32'h0);
      chk("rst/rden", {31'b0, o_csram_rden}, 32'h0);
      chk("rst/wren", {31'b0, o_csram_wren}, 32'h0);
      chk("rst/err", {31'b0, o_err}, 32'h0);
      chk("rst/addr", o_csram_addr_32b, 32'h0);
      chk("rst/din", o_csram_din_32b, 32'h0);
      chk("rst/rdata", o_rdata_32b, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst/ready_after_release", {31'b0, o_ready}, 32'h1);

      // Directed vector table.
      for (int i = 0; i < 10; i++) begin
         run_txn(vecs[i].name, vecs[i].we, vecs[i].strb, vecs[i].addr, vecs[i].wdata, vecs[i].lat,
                 vecs[i].exp_rdata, vecs[i].exp_din, vecs[i].exp_rd, vecs[i].exp_wr, 1'b0, vecs[i].stray);
      end

      // Reset while waiting for read data: no response, pending completion ignored.
      @(negedge clk);
      lat_cfg = 8;
      i_req = 1'b1; i_we = 1'b0; i_wstrb_4b = 4'h0; i_addr_32b = 32'h30;
      @(negedge clk);
      i_req = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst/ready", {31'b0, o_ready}, 32'h1);
      chk("midrst/resp_valid", {31'b0, o_resp_valid}, 32'h0);
      chk("midrst/addr", o_csram_addr_32b, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o_resp_valid || !o_ready) seen++;
      end
      chk("midrst/no_resp_idle", seen, 0);
      ref_mem[12] = 32'hC0FFEE01;
      run_txn("postrst_wr", 1'b1, 4'hF, 32'h30, 32'hC0FFEE01, 2, 32'h0, 32'hC0FFEE01, 0, 1, 1'b0, 0);
      run_txn("postrst_rd", 1'b0, 4'h0, 32'h31, 32'h0, 2, 32'hC0FFEE01, 32'h0, 1, 0, 1'b0, 0);

`ifdef CSRAM_TIMEOUT_EN
      // Unanswered accesses abort with o_err; late valids are ignored.
      mute = 1'b1;
      run_txn("to_rd", 1'b0, 4'h0, 32'h40, 32'h0, 1, 32'h0, 32'h0, 1, 0, 1'b1, 2);
      run_txn("to_rmw", 1'b1, 4'h3, 32'h44, 32'h12345678, 1, 32'h0, 32'h0, 1, 0, 1'b1, 2);
      mute = 1'b0;
      run_txn("to_next_rd", 1'b0, 4'h0, 32'h40, 32'h0, 2, ref_mem[16], 32'h0, 1, 0, 1'b0, 0);
      run_txn("to_next_rd2", 1'b0, 4'h0, 32'h44, 32'h0, 3, ref_mem[17], 32'h0, 1, 0, 1'b0, 0);
`endif

      // Randomized traffic against the reference memory (words 16..63).
      for (int t = 0; t < 40; t++) begin
         k     = $urandom_range(0, 3);
         addr  = 32'($urandom_range(64, 255));
         wdata = $urandom;
         w     = int'(addr) / 4;
         e_rd  = 32'h0; e_din = 32'h0; e_nrd = 0; e_nwr = 0;
         if (k == 0) begin
            we = 1'b0; strb = 4'($urandom);
            e_rd = ref_mem[w]; e_nrd = 1;
         end else if (k == 1) begin
            we = 1'b1; strb = 4'hF;
            e_din = wdata; ref_mem[w] = wdata; e_nwr = 1;
         end else if (k == 2) begin
            we = 1'b1; strb = 4'h0;
         end else begin
            we = 1'b1; strb = 4'($urandom_range(1, 14));
            e_din = merge_ref(ref_mem[w], wdata, strb);
            ref_mem[w] = e_din; e_nrd = 1; e_nwr = 1;
         end
         run_txn($sformatf("rand%0d", t), we, strb, addr, wdata, $urandom_range(1, 6),
                 e_rd, e_din, e_nrd, e_nwr, 1'b0, $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
